tug_of_war_core: RTL and testbench



---
 rtl/tow_pkg.sv | 18 +
 rtl/tug_of_war_core_key_edge.sv | 18 +
 rtl/tug_of_war_core.sv | 135 +++++++++++++
 tb/tb_tug_of_war_core.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game engine.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY,
    PAUSE,
    GAME_OVER
  } tow_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  // XNOR feedback taps for the 10-bit computer-player LFSR (lock-up state is all ones)
  localparam int unsigned LFSR_TAP_HI = 9;
  localparam int unsigned LFSR_TAP_LO = 6;

endpackage

// File: rtl/tug_of_war_core_key_edge.sv
// Rising-edge detector for a synchronous button level: one pulse per press.
module key_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/tug_of_war_core.sv
// Tug-of-war game engine: single position register, round/score FSM and an
// optional LFSR-driven computer opponent on the right side.
module tug_of_war_core
  import tow_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS   = 9,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SCORE_W      = 3,
  parameter int unsigned PAUSE_CYCLES = 4,
  parameter int unsigned LFSR_W       = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  key_l,
  input  logic                  key_r,
  input  logic                  cpu_en,
  input  logic                  cpu_tick,
  input  logic [LFSR_W-1:0]     difficulty,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  round_done,
  output logic [1:0]            winner
);

  localparam int unsigned POS_W = $clog2(NUM_LIGHTS);
  localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [POS_W-1:0]   POS_C      = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  tow_state_t          state, state_d;
  logic [POS_W-1:0]    pos, pos_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [SCORE_W-1:0]  score_l_d, score_r_d;
  logic [1:0]          winner_d;
  logic                round_done_d;
  logic [NUM_LIGHTS-1:0] leds_d;
  logic [LFSR_W-1:0]   lfsr;
  logic                p_l, p_r, e_l, e_r;

  key_edge u_edge_l (.Clock(Clock), .Reset(Reset), .level(key_l), .pulse(p_l));
  key_edge u_edge_r (.Clock(Clock), .Reset(Reset), .level(key_r), .pulse(p_r));

  assign e_l = p_l;
  assign e_r = cpu_en ? (cpu_tick & (lfsr < difficulty)) : p_r;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) lfsr <= '0;
    else       lfsr <= {lfsr[LFSR_W-2:0], ~(lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO])};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= PLAY;
      pos        <= POS_C;
      cnt        <= '0;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= WIN_NONE;
      round_done <= 1'b0;
      leds       <= NUM_LIGHTS'(1) << POS_C;
    end else begin
      state      <= state_d;
      pos        <= pos_d;
      cnt        <= cnt_d;
      score_l    <= score_l_d;
      score_r    <= score_r_d;
      winner     <= winner_d;
      round_done <= round_done_d;
      leds       <= leds_d;
    end
  end

  always_comb begin
    state_d      = state;
    pos_d        = pos;
    cnt_d        = cnt;
    score_l_d    = score_l;
    score_r_d    = score_r;
    winner_d     = winner;
    round_done_d = 1'b0;
    unique case (state)
      PLAY: begin
        if (e_l && !e_r) begin
          if (pos == POS_MAX) begin
            score_l_d    = score_l + SCORE_W'(1);
            round_done_d = 1'b1;
            if (score_l_d == SCORE_WIN) begin
              state_d  = GAME_OVER;
              winner_d = WIN_L;
            end else begin
              state_d = PAUSE;
              cnt_d   = PAUSE_LOAD;
            end
          end else begin
            pos_d = pos + POS_W'(1);
          end
        end else if (e_r && !e_l) begin
          if (pos == '0) begin
            score_r_d    = score_r + SCORE_W'(1);
            round_done_d = 1'b1;
            if (score_r_d == SCORE_WIN) begin
              state_d  = GAME_OVER;
              winner_d = WIN_R;
            end else begin
              state_d = PAUSE;
              cnt_d   = PAUSE_LOAD;
            end
          end else begin
            pos_d = pos - POS_W'(1);
          end
        end
      end
      PAUSE: begin
        if (cnt == '0) begin
          state_d = PLAY;
          pos_d   = POS_C;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAME_OVER: ;
      default: state_d = PLAY;
    endcase
  end

  // LEDs are registered from next-state values so a move shows at the same edge
  always_comb begin
    leds_d = '0;
    if (state_d == PLAY) leds_d = NUM_LIGHTS'(1) << pos_d;
  end

endmodule

// File: tb/tb_tug_of_war_core.sv
// Directed self-checking bench for tug_of_war_core.
module tb_tug_of_war_core;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       key_l = 1'b0;
  logic       key_r = 1'b0;
  logic       cpu_en = 1'b0;
  logic       cpu_tick = 1'b0;
  logic [9:0] difficulty = '0;
  logic [8:0] leds;
  logic [2:0] score_l, score_r;
  logic       round_done;
  logic [1:0] winner;

  int unsigned checks = 0;
  int unsigned errors = 0;

  tug_of_war_core #(
    .NUM_LIGHTS(9), .WIN_SCORE(7), .SCORE_W(3), .PAUSE_CYCLES(4), .LFSR_W(10)
  ) dut (
    .Clock(Clock), .Reset(Reset), .key_l(key_l), .key_r(key_r),
    .cpu_en(cpu_en), .cpu_tick(cpu_tick), .difficulty(difficulty),
    .leds(leds), .score_l(score_l), .score_r(score_r),
    .round_done(round_done), .winner(winner)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    key_l = 1'b0; key_r = 1'b0;
    cpu_en = 1'b0; cpu_tick = 1'b0; difficulty = '0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic press_l();
    key_l = 1'b1; tick(); key_l = 1'b0; tick();
  endtask

  task automatic press_r();
    key_r = 1'b1; tick(); key_r = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (leds !== 9'b000010000) begin errors++; $display("FAIL reset_leds got=%b exp=%b", leds, 9'b000010000); end
    checks++;
    if (score_l !== 3'd0 || score_r !== 3'd0) begin errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_l, score_r); end
    checks++;
    if (winner !== 2'b00 || round_done !== 1'b0) begin errors++; $display("FAIL reset_flags got winner=%b rd=%b exp=00/0", winner, round_done); end
  endtask

  task automatic test_hold();
    do_reset();
    key_l = 1'b1;
    repeat (10) tick();
    key_l = 1'b0;
    checks++;
    if (leds !== 9'b000100000) begin errors++; $display("FAIL hold_one_move got=%b exp=%b", leds, 9'b000100000); end
    tick();
  endtask

  task automatic test_round_win();
    do_reset();
    repeat (4) press_l();
    checks++;
    if (leds !== 9'b100000000) begin errors++; $display("FAIL left_edge got=%b exp=%b", leds, 9'b100000000); end
    key_l = 1'b1; tick();
    checks++;
    if (round_done !== 1'b1 || score_l !== 3'd1 || leds !== 9'b0) begin
      errors++; $display("FAIL round_win got rd=%b sl=%0d leds=%b exp 1/1/0", round_done, score_l, leds);
    end
    key_l = 1'b0; tick();
    checks++;
    if (round_done !== 1'b0) begin errors++; $display("FAIL round_done_pulse got=%b exp=0", round_done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (leds !== 9'b0) begin errors++; $display("FAIL pause_dark[%0d] got=%b exp=0", i, leds); end
      tick();
    end
    checks++;
    if (leds !== 9'b000010000) begin errors++; $display("FAIL pause_exit got=%b exp=%b", leds, 9'b000010000); end
  endtask

  task automatic test_cancel_and_right();
    do_reset();
    key_l = 1'b1; key_r = 1'b1; tick();
    key_l = 1'b0; key_r = 1'b0;
    checks++;
    if (leds !== 9'b000010000) begin errors++; $display("FAIL cancel got=%b exp=%b", leds, 9'b000010000); end
    tick();
    repeat (4) press_r();
    checks++;
    if (leds !== 9'b000000001) begin errors++; $display("FAIL right_edge got=%b exp=%b", leds, 9'b000000001); end
    key_r = 1'b1; tick(); key_r = 1'b0;
    checks++;
    if (score_r !== 3'd1 || score_l !== 3'd0 || round_done !== 1'b1) begin
      errors++; $display("FAIL right_win got sr=%0d sl=%0d rd=%b exp 1/0/1", score_r, score_l, round_done);
    end
    tick();
  endtask

  task automatic test_game_over();
    do_reset();
    for (int r = 0; r < 7; r++) begin
      repeat (4) press_l();
      key_l = 1'b1; tick(); key_l = 1'b0;
      checks++;
      if (score_l !== 3'(r + 1)) begin errors++; $display("FAIL round_score[%0d] got=%0d exp=%0d", r, score_l, r + 1); end
      tick();
      if (r < 6) repeat (3) tick();
    end
    checks++;
    if (winner !== 2'b01) begin errors++; $display("FAIL winner_left got=%b exp=01", winner); end
    repeat (3) press_l();
    repeat (2) press_r();
    checks++;
    if (leds !== 9'b0 || score_l !== 3'd7 || score_r !== 3'd0 || winner !== 2'b01) begin
      errors++; $display("FAIL game_over_hold got leds=%b sl=%0d sr=%0d w=%b exp 0/7/0/01", leds, score_l, score_r, winner);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (leds !== 9'b000010000 || score_l !== 3'd0 || winner !== 2'b00) begin
      errors++; $display("FAIL game_over_reset got leds=%b sl=%0d w=%b exp centre/0/00", leds, score_l, winner);
    end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_cpu();
    do_reset();
    cpu_en = 1'b1; cpu_tick = 1'b1; difficulty = 10'd0;
    for (int i = 0; i < 5; i++) begin
      key_r = 1'b1; tick(); key_r = 1'b0; tick();
    end
    checks++;
    if (leds !== 9'b000010000) begin errors++; $display("FAIL cpu_diff0 got=%b exp=%b", leds, 9'b000010000); end

    // lfsr is 0 only on the first edge after reset, so difficulty 1 gives one move
    do_reset();
    cpu_en = 1'b1; cpu_tick = 1'b1; difficulty = 10'd1;
    repeat (6) tick();
    checks++;
    if (leds !== 9'b000001000) begin errors++; $display("FAIL cpu_diff1 got=%b exp=%b", leds, 9'b000001000); end

    do_reset();
    cpu_en = 1'b1; cpu_tick = 1'b1; difficulty = 10'h3FF;
    repeat (4) tick();
    checks++;
    if (leds !== 9'b000000001 || score_r !== 3'd0) begin
      errors++; $display("FAIL cpu_run got leds=%b sr=%0d exp %b/0", leds, score_r, 9'b000000001);
    end
    tick();
    checks++;
    if (score_r !== 3'd1 || round_done !== 1'b1) begin errors++; $display("FAIL cpu_win got sr=%0d rd=%b exp 1/1", score_r, round_done); end
    cpu_tick = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pause();
    do_reset();
    repeat (4) press_l();
    key_l = 1'b1; tick(); key_l = 1'b0;
    tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (leds !== 9'b000010000 || score_l !== 3'd0 || round_done !== 1'b0) begin
      errors++; $display("FAIL pause_async_reset got leds=%b sl=%0d rd=%b exp centre/0/0", leds, score_l, round_done);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (leds !== 9'b000010000) begin errors++; $display("FAIL pause_reset_resume got=%b exp=%b", leds, 9'b000010000); end
    press_l();
    checks++;
    if (leds !== 9'b000100000) begin errors++; $display("FAIL pause_reset_play got=%b exp=%b", leds, 9'b000100000); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_round_win();
    test_cancel_and_right();
    test_game_over();
    test_cpu();
    test_reset_mid_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
